// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V sequencer.
// Covers the state enum, opcodes, ALU codes and datapath mux selects.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, UIMM, TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_FUNCT
  } alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control: fixed add/sub for sequencing states,
// funct3/funct7b5 decode for R and I execute states.
module mc_alu_decoder
  import riscv_mc_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_r,
  output logic [3:0] alu_control
);

  // Immediate forms only honour the alternate bit on shifts-right, so addi
  // with imm[10] set stays add and slli with it set stays sll.
  logic alt;
  assign alt = funct7b5 & (op_r | (funct3 == 3'b101));

  always_comb begin
    alu_control = ALU_ADD;
    case (cls)
      ALU_CLS_SUB: alu_control = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = alt ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V sequencer: Moore FSM driving the shared memory port,
// IR/PC/ALUOut/Data registers and register file, with illegal/timeout traps.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <= rs1+imm
// MEMREAD  | read data at ALUOut
// MEMWB    | rd <= Data
// MEMWRITE | write rs2 at ALUOut
// EXECR    | ALUOut <= rs1 op rs2
// EXECI    | ALUOut <= rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare, PC <= ALUOut when taken
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// JALR     | ALUOut <= rs1+imm
// UIMM     | ALUOut <= PC/zero + U-imm
// TRAP     | halted until reset
module riscv_mc_controller
  import riscv_mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TCW            = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  state_t         state, state_next;
  logic [TCW-1:0] wait_cnt;
  logic           mem_wait, timeout;
  alu_cls_t       alu_cls;
  logic           req_m, mw_m, irw_m, pcw_m, rw_m;

  assign mem_wait = state inside {FETCH, MEMREAD, MEMWRITE};
  assign timeout  = (TIMEOUT_CYCLES != 0) && mem_wait && !mem_ready &&
                    (wait_cnt == TCW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (state_next != state)     wait_cnt <= '0;
      else if (mem_wait && !mem_ready) wait_cnt <= wait_cnt + TCW'(1);
      if (state == DECODE && state_next == TRAP) illegal <= 1'b1;
      if (timeout) bus_err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (mem_ready) state_next = DECODE; else if (timeout) state_next = TRAP;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_R:              state_next = EXECR;
          OP_I:              state_next = EXECI;
          OP_BRANCH:         state_next = BRANCH;
          OP_JAL:            state_next = JAL;
          OP_JALR:           state_next = JALR;
          OP_LUI, OP_AUIPC:  state_next = UIMM;
          default:           state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_next = MEMWB; else if (timeout) state_next = TRAP;
      MEMWRITE: if (mem_ready) state_next = FETCH; else if (timeout) state_next = TRAP;
      MEMWB, ALUWB, BRANCH: state_next = FETCH;
      EXECR, EXECI, JAL, UIMM: state_next = ALUWB;
      JALR:     state_next = JAL;
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    req_m = 1'b0; mw_m = 1'b0; irw_m = 1'b0; pcw_m = 1'b0; rw_m = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    alu_cls   = ALU_CLS_ADD;
    case (state)
      FETCH: begin
        req_m = 1'b1; irw_m = mem_ready; pcw_m = mem_ready;
        ALUSrcB = SRCB_FOUR; ResultSrc = RES_ALURESULT;
      end
      DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      MEMADR:   begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; end
      MEMREAD:  begin req_m = 1'b1; AdrSrc = 1'b1; end
      MEMWB:    begin rw_m = 1'b1; ResultSrc = RES_DATA; end
      MEMWRITE: begin req_m = 1'b1; mw_m = 1'b1; AdrSrc = 1'b1; end
      EXECR:    begin ALUSrcA = SRCA_RS1; alu_cls = ALU_CLS_FUNCT; end
      EXECI:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; alu_cls = ALU_CLS_FUNCT; end
      ALUWB:    rw_m = 1'b1;
      BRANCH:   begin ALUSrcA = SRCA_RS1; alu_cls = ALU_CLS_SUB; pcw_m = branch_taken; end
      JALR:     begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; end
      JAL:      begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_FOUR; pcw_m = 1'b1; end
      UIMM:     begin ALUSrcA = op[5] ? SRCA_ZERO : SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      default:  ;
    endcase
  end

  // The reset state is FETCH, so strobes are gated until reset_n releases.
  assign mem_req   = req_m & reset_n;
  assign MemWrite  = mw_m  & reset_n;
  assign IRWrite   = irw_m & reset_n;
  assign PCWrite   = pcw_m & reset_n;
  assign RegWrite  = rw_m  & reset_n;
  assign ImmSrc    = imm_sel(op);
  assign state_dbg = state;

  mc_alu_decoder u_alu_dec (
    .cls         (alu_cls),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op_r        (op == OP_R),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboarded bench: instruction-level reference model pushes per-cycle
// expectations; a negedge monitor pops and compares against the DUT.
module tb_riscv_mc_controller;

  localparam int TO = 4;

  localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                         S_MEMREAD = 4'd3, S_MEMWB = 4'd4,  S_MEMWRITE = 4'd5,
                         S_EXECR = 4'd6,  S_EXECI = 4'd7,   S_ALUWB = 4'd8,
                         S_BRANCH = 4'd9, S_JAL = 4'd10,    S_JALR = 4'd11,
                         S_UIMM = 4'd12,  S_TRAP = 4'd13;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, branch_taken, mem_ready;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, state_dbg;
  logic       illegal, bus_err;

  always #5 clk = ~clk;

  riscv_mc_controller #(.TIMEOUT_CYCLES(TO), .TCW(8)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       req, mw, irw, pcw, rw, adr;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic       ill, berr;
  } obs_t;

  obs_t  exp_q[$], msk_q[$];
  string tag_q[$];
  int    errors = 0, checks = 0;
  logic  ill_m, berr_m;

  always @(negedge clk) begin
    obs_t e, m, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      a = '{st: state_dbg, req: mem_req, mw: MemWrite, irw: IRWrite, pcw: PCWrite,
            rw: RegWrite, adr: AdrSrc, rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB,
            alu: ALUControl, imm: ImmSrc, ill: illegal, berr: bus_err};
      checks++;
      if ((a & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s @%0t: got %h required %h (mask %h)", t, $time, a & m, e & m, m);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h required %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] imm_ref(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'd1;
      7'b1100011:             return 3'd2;
      7'b1101111:             return 3'd3;
      7'b0110111, 7'b0010111: return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

  // Mnemonic-level ALU expectation for R/I instructions.
  function automatic int alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0: return (o == 7'b0110011 && f7) ? 1 : 0;
      3'd1: return 6;
      3'd2: return 5;
      3'd3: return 13;
      3'd4: return 4;
      3'd5: return f7 ? 15 : 7;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  // One cycle: mux fields given as -1 are not checked.
  task automatic ph(input string tag, input logic [3:0] st, input logic req, mw, irw, pcw, rw,
                    input int adr, rs, sa, sb, alu, input bit kill = 1'b0);
    obs_t e, m;
    e = '0; m = '0;
    e.st = st; m.st = '1;
    e.req = req; e.mw = mw; e.irw = irw; e.pcw = pcw; e.rw = rw;
    m.req = 1'b1; m.mw = 1'b1; m.irw = 1'b1; m.pcw = 1'b1; m.rw = 1'b1;
    e.imm = imm_ref(op); m.imm = '1;
    e.ill = ill_m; e.berr = berr_m; m.ill = 1'b1; m.berr = 1'b1;
    if (adr >= 0) begin e.adr = adr[0];   m.adr = 1'b1; end
    if (rs  >= 0) begin e.rs  = rs[1:0];  m.rs  = '1;   end
    if (sa  >= 0) begin e.sa  = sa[1:0];  m.sa  = '1;   end
    if (sb  >= 0) begin e.sb  = sb[1:0];  m.sb  = '1;   end
    if (alu >= 0) begin e.alu = alu[3:0]; m.alu = '1;   end
    exp_q.push_back(e); msk_q.push_back(m); tag_q.push_back(tag);
    if (kill) begin #1 reset_n = 1'b0; end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0; mem_ready = 1'b0;
    ill_m = 1'b0; berr_m = 1'b0;
    for (int i = 0; i < n; i++) ph("reset", S_FETCH, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1);
    reset_n = 1'b1;
  endtask

  task automatic trap_cycles(input string nm);
    ph({nm, ".trap"}, S_TRAP, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1);
    ph({nm, ".trap"}, S_TRAP, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1);
  endtask

  // Memory wait: ready after n idle cycles, or never when n exceeds the
  // timeout, in which case TO+1 cycles are spent waiting before the trap.
  task automatic mem_phase(input string nm, input logic [3:0] st, input logic wr,
                           input int n, output bit ok);
    int last;
    ok = (n <= TO);
    last = ok ? n : TO;
    for (int i = 0; i <= last; i++) begin
      mem_ready = ok && (i == n);
      ph({nm, wr ? ".MW" : ".MR"}, st, 1, wr, 0, 0, 0, 1, -1, -1, -1, -1);
    end
    mem_ready = 1'b0;
    if (!ok) begin
      berr_m = 1'b1;
      trap_cycles(nm);
    end
  endtask

  task automatic run(input string nm, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic bt, input int fw, input int mw);
    bit ok;
    op = o; funct3 = f3; funct7b5 = f7; branch_taken = bt;
    for (int i = 0; i <= fw; i++) begin
      mem_ready = (i == fw);
      ph({nm, ".F"}, S_FETCH, 1, 0, mem_ready, mem_ready, 0, 0, 2, 0, 2, 0);
    end
    mem_ready = 1'b0;
    ph({nm, ".D"}, S_DECODE, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0);
    case (o)
      7'b0000011: begin
        ph({nm, ".A"}, S_MEMADR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0);
        mem_phase(nm, S_MEMREAD, 1'b0, mw, ok);
        if (ok) ph({nm, ".WB"}, S_MEMWB, 0, 0, 0, 0, 1, -1, 1, -1, -1, -1);
      end
      7'b0100011: begin
        ph({nm, ".A"}, S_MEMADR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0);
        mem_phase(nm, S_MEMWRITE, 1'b1, mw, ok);
      end
      7'b0110011: begin
        ph({nm, ".X"}, S_EXECR, 0, 0, 0, 0, 0, -1, -1, 2, 0, alu_ref(o, f3, f7));
        ph({nm, ".WB"}, S_ALUWB, 0, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      7'b0010011: begin
        ph({nm, ".X"}, S_EXECI, 0, 0, 0, 0, 0, -1, -1, 2, 1, alu_ref(o, f3, f7));
        ph({nm, ".WB"}, S_ALUWB, 0, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      7'b1100011:
        ph({nm, ".B"}, S_BRANCH, 0, 0, 0, bt, 0, -1, 0, 2, 0, 1);
      7'b1101111, 7'b1100111: begin
        if (o[3] == 1'b0) ph({nm, ".JR"}, S_JALR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0);
        ph({nm, ".J"}, S_JAL, 0, 0, 0, 1, 0, -1, 0, 1, 2, 0);
        ph({nm, ".WB"}, S_ALUWB, 0, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      7'b0110111, 7'b0010111: begin
        ph({nm, ".U"}, S_UIMM, 0, 0, 0, 0, 0, -1, -1, o[5] ? 3 : 1, 1, 0);
        ph({nm, ".WB"}, S_ALUWB, 0, 0, 0, 0, 1, -1, 0, -1, -1, -1);
      end
      default: begin
        ill_m = 1'b1;
        trap_cycles(nm);
      end
    endcase
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    reset_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b0; ill_m = 1'b0; berr_m = 1'b0;
    @(posedge clk); #1;
    chk("reset.state", 32'(state_dbg), 32'(S_FETCH));
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.MemWrite", 32'(MemWrite), 32'd0);
    chk("reset.RegWrite", 32'(RegWrite), 32'd0);
    chk("reset.illegal", 32'(illegal), 32'd0);
    chk("reset.bus_err", 32'(bus_err), 32'd0);
    do_reset(2);

    run("stall",  7'b0110011, 3'd0, 1'b0, 1'b0, 3, 0);
    run("lw",     7'b0000011, 3'd2, 1'b0, 1'b0, 0, 0);
    run("sw",     7'b0100011, 3'd2, 1'b0, 1'b0, 0, 2);
    run("sub",    7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
    run("srai",   7'b0010011, 3'd5, 1'b1, 1'b0, 0, 0);
    run("slli7",  7'b0010011, 3'd1, 1'b1, 1'b0, 0, 0);
    run("addi7",  7'b0010011, 3'd0, 1'b1, 1'b0, 0, 0);
    run("bne_nt", 7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
    run("beq_t",  7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
    run("jal",    7'b1101111, 3'd0, 1'b0, 1'b0, 0, 0);
    run("jalr",   7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0);
    run("lui",    7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
    run("auipc",  7'b0010111, 3'd0, 1'b0, 1'b0, 0, 0);
    run("lw_edge", 7'b0000011, 3'd2, 1'b0, 1'b0, TO, TO);

    for (int k = 0; k < 40; k++)
      run("rnd", ops[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, TO), $urandom_range(0, TO));

    // Reset asserted mid-MEMWRITE: strobes and state must drop before the edge.
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
    mem_ready = 1'b1;
    ph("rstmid.F", S_FETCH, 1, 0, 1, 1, 0, 0, 2, 0, 2, 0);
    mem_ready = 1'b0;
    ph("rstmid.D", S_DECODE, 0, 0, 0, 0, 0, -1, -1, 1, 1, 0);
    ph("rstmid.A", S_MEMADR, 0, 0, 0, 0, 0, -1, -1, 2, 1, 0);
    ph("rstmid.MW", S_MEMWRITE, 1, 1, 0, 0, 0, 1, -1, -1, -1, -1);
    ph("rstmid.kill", S_FETCH, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, 1'b1);
    do_reset(1);
    run("post_rst", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, 1);

    run("ill", 7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
    do_reset(2);
    run("to_rd", 7'b0000011, 3'd2, 1'b0, 1'b0, 0, TO + 1);
    chk("to_rd.bus_err", 32'(bus_err), 32'd1);
    chk("to_rd.state", 32'(state_dbg), 32'(S_TRAP));
    do_reset(2);
    run("to_wr", 7'b0100011, 3'd2, 1'b0, 1'b0, 1, TO + 1);
    do_reset(2);
    run("final", 7'b0110011, 3'd7, 1'b0, 1'b0, 0, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_mc_controller.md
Name: riscv_mc_controller

Overview:
- Multicycle sequencer for the RISC-V core. It replaces the single-cycle maindec/PCSrc path with a Moore FSM that drives a shared instruction/data memory port, the IR, PC, ALUOut and Data registers, and the register file.
- It decodes RV32I lw/sw/R/I/B/jal/jalr/lui/auipc. It waits on a memory ready handshake and traps on illegal opcodes or memory timeout.
- It sits between the instruction register fields and the multicycle datapath.

Parameters:
- TIMEOUT_CYCLES, 255: maximum wait cycles for mem_ready in any memory state before bus_err. 0 disables the timeout.
- TCW, 8: width of the timeout counter. It must satisfy TIMEOUT_CYCLES < 2**TCW.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  Instr[6:0] from IR.
- funct3  in  3  Instr[14:12].
- funct7b5  in  1  Instr[30].
- branch_taken  in  1  branch comparator result for funct3 (beq/bne/blt/bge/bltu/bgeu).
- mem_ready  in  1  memory completed the current request this cycle.
- mem_req  out  1  memory access request.
- MemWrite  out  1  write qualifier for mem_req.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A, 11 = zero.
- ALUSrcB  out  2  00 = rs2 register B, 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- ALUControl  out  4  team ALU encoding: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sltu 1101, sra 1111.
- illegal  out  1  sticky illegal-opcode flag.
- bus_err  out  1  sticky memory-timeout flag.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset: asynchronous entry to FETCH, timeout counter = 0, illegal = bus_err = 0.
  - While reset_n = 0, mem_req, MemWrite, IRWrite, PCWrite and RegWrite are forced to 0.
  - The first fetch request is issued in the first cycle after reset_n rises.
- Outputs are Moore, a function of the state only, with these exceptions:
  - PCWrite/IRWrite in FETCH are qualified by mem_ready.
  - PCWrite in BRANCH is qualified by branch_taken.
  - ImmSrc is decoded from op in every state.
- FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
  - mem_ready = 1: IRWrite = PCWrite = 1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, add (precomputes branch/jal target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 or 0010111 -> UIMM
  - anything else -> TRAP with illegal = 1
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, add. Go to MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: mem_req = 1, AdrSrc = 1. On mem_ready go to MEMWB, else stay.
- MEMWB: ResultSrc = 01, RegWrite = 1, go to FETCH.
- MEMWRITE: mem_req = MemWrite = 1, AdrSrc = 1, both held constant until mem_ready. On mem_ready go to FETCH.
- EXECR: ALUSrcA = 10, ALUSrcB = 00, then ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, then ALUWB.
- ALUWB: ResultSrc = 00, RegWrite = 1, go to FETCH.
- BRANCH: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00, PCWrite = branch_taken, go to FETCH.
- JALR: ALUSrcA = 10, ALUSrcB = 01, add (target into ALUOut), go to JAL. The datapath clears bit 0 of the target.
- JAL: ALUSrcA = 01, ALUSrcB = 10, add, ResultSrc = 00, PCWrite = 1, go to ALUWB (ALUWB writes OldPC+4 to rd).
- UIMM: ALUSrcA = 01 if op[5] = 0 (auipc), 11 if op[5] = 1 (lui). ALUSrcB = 01, add. Go to ALUWB.
- TRAP: all strobes 0. Stays in TRAP until reset. illegal and bus_err hold their values.
- ALU decode:
  - FETCH/MEMADR/JAL/JALR/UIMM/DECODE use add; BRANCH uses sub.
  - EXECR/EXECI decode funct3.
  - The sub/sra bit = funct7b5 & (op == 0110011 | funct3 == 101).
  - slli/srli/srai with funct7b5 = 1 on funct3 = 001 still yields sll.
- Timeout:
  - The counter increments each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready = 0.
  - It clears on any state change.
  - When the count equals TIMEOUT_CYCLES with mem_ready still 0: bus_err = 1, go to TRAP.
  - If mem_ready and the timeout coincide, mem_ready wins.
- Cycle counts with zero-wait memory:
  - lw 5
  - sw 4
  - R/I/jal/auipc/lui 4
  - jalr 5
  - branch 3

Decomposition:
- Package riscv_mc_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UIMM, TRAP)
  - opcode constants
  - ALUControl constants
  - mux-select constants (ALUSrcA/B, ResultSrc, ImmSrc)
- Sub-module mc_alu_decoder: purely combinational mapping of state class, funct3 and funct7b5 to ALUControl.

Test Plan:
- Fetch stall: reset, then hold mem_ready = 0 for 3 cycles -> FETCH held for 4 cycles; IRWrite = PCWrite = 1 only in the cycle mem_ready = 1; DECODE follows.
- lw x5,8(x1) (op 0000011) with zero-wait memory -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite = 1 with ResultSrc = 01 only in cycle 5.
- sw with mem_ready delayed 2 cycles -> MemWrite = mem_req = 1 and AdrSrc = 1 stable for 3 cycles, then FETCH. RegWrite never asserts.
- R-type sub (funct3 000, funct7b5 = 1) -> ALUControl = 0001 in EXECR. srai (op 0010011, funct3 101, funct7b5 = 1) -> 1111. bne with branch_taken = 0 -> PCWrite = 0 in BRANCH.
- Illegal op 1111111 -> TRAP after DECODE, illegal = 1 sticky, no strobes. Assert reset_n = 0 mid-MEMWRITE -> MemWrite drops immediately, FETCH after release.
- TIMEOUT_CYCLES = 4, mem_ready never asserted in MEMREAD -> bus_err = 1 after 4 waiting cycles, TRAP entered.
